// File: rtl/sal_cmd_sched.sv
// ---------------------------------------------------------------------------
// sal_cmd_sched
//   Round-robin command scheduler between the per-bank controllers and the
//   shared DFI command bus. Each cycle at most one bank command (ACT, RD, WR,
//   PRE) is granted. Inter-bank tRRD (ACT->ACT) and tCCD (CAS->CAS) timers
//   gate eligibility. The winner is driven onto registered DFI outputs one
//   cycle after the grant.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid_i     per-bank request valid
//   req_cmd_i       per-bank 3-bit command (1 ACT, 2 RD, 3 WR, 4 PRE)
//   req_addr_i      per-bank row/column address
//   gnt_o           one-hot grant, combinational, request consumed this cycle
//   t_rrd_i         tRRD in clocks (quasi-static)
//   t_ccd_i         tCCD in clocks (quasi-static)
//   dfi_*_o         registered DFI command, bank and address
// ---------------------------------------------------------------------------
module sal_cmd_sched #(
    parameter int BK_CNT = 4,
    parameter int BA_W   = 2,
    parameter int ADDR_W = 14,
    parameter int TW     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [BK_CNT-1:0]        req_valid_i,
    input  logic [BK_CNT*3-1:0]      req_cmd_i,
    input  logic [BK_CNT*ADDR_W-1:0] req_addr_i,
    output logic [BK_CNT-1:0]        gnt_o,
    input  logic [TW-1:0]            t_rrd_i,
    input  logic [TW-1:0]            t_ccd_i,
    output logic                     dfi_cs_n_o,
    output logic                     dfi_ras_n_o,
    output logic                     dfi_cas_n_o,
    output logic                     dfi_we_n_o,
    output logic [BA_W-1:0]          dfi_bank_o,
    output logic [ADDR_W-1:0]        dfi_address_o
);

    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    logic [BA_W-1:0]   rr_ptr;
    logic [TW-1:0]     rrd_cnt;
    logic [TW-1:0]     ccd_cnt;

    logic [2:0]        cmd_b  [BK_CNT];
    logic [ADDR_W-1:0] addr_b [BK_CNT];
    logic [BK_CNT-1:0] elig;

    logic              found;
    logic              grant;
    logic [BA_W-1:0]   winner;
    logic [BA_W-1:0]   idx;
    logic [2:0]        win_cmd;
    logic [3:0]        win_enc;
    logic              rrd_load;
    logic              ccd_load;

    // Split the flat request buses per bank and work out which banks may go.
    // Illegal command codes match none of the terms and are never eligible.
    for (genvar i = 0; i < BK_CNT; i++) begin : g_bank
        assign cmd_b[i]  = req_cmd_i[i*3 +: 3];
        assign addr_b[i] = req_addr_i[i*ADDR_W +: ADDR_W];
        assign elig[i]   = req_valid_i[i] &&
                           (((cmd_b[i] == CMD_ACT) && (rrd_cnt == '0)) ||
                            (((cmd_b[i] == CMD_RD) || (cmd_b[i] == CMD_WR)) && (ccd_cnt == '0)) ||
                            (cmd_b[i] == CMD_PRE));
    end

    // Scan starting at rr_ptr; the BA_W-bit add wraps because BK_CNT is a
    // power of two. Blocked banks are simply skipped.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < BK_CNT; k++) begin
            idx = rr_ptr + BA_W'(k);
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Requests held across reset must not be granted while reset is active.
    assign grant   = found && rst_n;
    assign win_cmd = cmd_b[winner];
    assign gnt_o   = grant ? (BK_CNT'(1) << winner) : '0;

    assign rrd_load = grant && (win_cmd == CMD_ACT);
    assign ccd_load = grant && ((win_cmd == CMD_RD) || (win_cmd == CMD_WR));

    // {cs_n, ras_n, cas_n, we_n} of the winning command.
    always_comb begin
        win_enc = 4'b1111;
        case (win_cmd)
            CMD_ACT: win_enc = 4'b0011;
            CMD_RD:  win_enc = 4'b0101;
            CMD_WR:  win_enc = 4'b0100;
            CMD_PRE: win_enc = 4'b0010;
            default: win_enc = 4'b1111;
        endcase
    end

    // Round-robin pointer moves past the winner only when something is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= winner + BA_W'(1);
        end
    end

    // Loading with t-1 makes the next same-class command legal exactly t
    // cycles later; a zero setting means back-to-back is allowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrd_cnt <= '0;
            ccd_cnt <= '0;
        end else begin
            if (rrd_load) begin
                rrd_cnt <= (t_rrd_i == '0) ? '0 : t_rrd_i - TW'(1);
            end else if (rrd_cnt != '0) begin
                rrd_cnt <= rrd_cnt - TW'(1);
            end
            if (ccd_load) begin
                ccd_cnt <= (t_ccd_i == '0) ? '0 : t_ccd_i - TW'(1);
            end else if (ccd_cnt != '0) begin
                ccd_cnt <= ccd_cnt - TW'(1);
            end
        end
    end

    // Registered DFI command; bank/address hold during NOP cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dfi_cs_n_o    <= 1'b1;
            dfi_ras_n_o   <= 1'b1;
            dfi_cas_n_o   <= 1'b1;
            dfi_we_n_o    <= 1'b1;
            dfi_bank_o    <= '0;
            dfi_address_o <= '0;
        end else if (grant) begin
            {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} <= win_enc;
            dfi_bank_o    <= winner;
            dfi_address_o <= addr_b[winner];
        end else begin
            {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} <= 4'b1111;
        end
    end

endmodule

// File: tb/tb_sal_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_sal_cmd_sched
//   Directed self-checking bench for sal_cmd_sched (4 banks, 14-bit address).
//   Inputs change 1 time unit after the rising edge; grant and DFI outputs
//   are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sal_cmd_sched;

    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    localparam logic [3:0] ENC_ACT = 4'b0011;
    localparam logic [3:0] ENC_RD  = 4'b0101;
    localparam logic [3:0] ENC_WR  = 4'b0100;
    localparam logic [3:0] ENC_PRE = 4'b0010;
    localparam logic [3:0] ENC_NOP = 4'b1111;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [11:0] req_cmd;
    logic [55:0] req_addr;
    logic [3:0]  gnt;
    logic [3:0]  t_rrd;
    logic [3:0]  t_ccd;
    logic        dfi_cs_n;
    logic        dfi_ras_n;
    logic        dfi_cas_n;
    logic        dfi_we_n;
    logic [1:0]  dfi_bank;
    logic [13:0] dfi_address;

    int total;
    int bad;

    sal_cmd_sched #(
        .BK_CNT(4),
        .BA_W  (2),
        .ADDR_W(14),
        .TW    (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_cmd_i    (req_cmd),
        .req_addr_i   (req_addr),
        .gnt_o        (gnt),
        .t_rrd_i      (t_rrd),
        .t_ccd_i      (t_ccd),
        .dfi_cs_n_o   (dfi_cs_n),
        .dfi_ras_n_o  (dfi_ras_n),
        .dfi_cas_n_o  (dfi_cas_n),
        .dfi_we_n_o   (dfi_we_n),
        .dfi_bank_o   (dfi_bank),
        .dfi_address_o(dfi_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic checkDfi(input string tag, input logic [3:0] enc,
                            input int bank, input int addr);
        checkOutput({tag, "_cmd"}, {28'd0, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}, {28'd0, enc});
        checkOutput({tag, "_bank"}, {30'd0, dfi_bank}, 32'(bank));
        checkOutput({tag, "_addr"}, {18'd0, dfi_address}, 32'(addr));
    endtask

    task automatic applyStimulus(input int b, input logic v, input logic [2:0] c,
                                 input logic [13:0] a);
        req_valid[b]        = v;
        req_cmd[b*3 +: 3]   = c;
        req_addr[b*14 +: 14] = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] mixed_enc(input int b);
        case (b)
            0:       return ENC_ACT;
            1:       return ENC_WR;
            2:       return ENC_ACT;
            default: return ENC_RD;
        endcase
    endfunction

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_cmd   = '0;
        req_addr  = '0;
        t_rrd     = 4'd0;
        t_ccd     = 4'd0;

        // Reset held with every bank requesting PRE.
        for (int b = 0; b < 4; b++) applyStimulus(b, 1'b1, CMD_PRE, 14'(14'h100 + b));
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_gnt", 32'(gnt), 32'd0);
            checkDfi("rst", ENC_NOP, 0, 0);
        end
        tick();
        rst_n = 1'b1;

        // Round-robin over four held PRE requests.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("rr_gnt", 32'(gnt), 32'(1) << (k % 4));
            if (k > 0) checkDfi("rr_dfi", ENC_PRE, (k - 1) % 4, 'h100 + (k - 1) % 4);
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        checkOutput("rr_idle_gnt", 32'(gnt), 32'd0);
        checkDfi("rr_last", ENC_PRE, 0, 'h100);
        tick();
        @(negedge clk);
        checkDfi("rr_nop", ENC_NOP, 0, 'h100);

        // tRRD = 4: rr_ptr is 1, so bank 1 goes first and bank 0 waits 4 cycles.
        tick();
        t_rrd = 4'd4;
        applyStimulus(0, 1'b1, CMD_ACT, 14'h0A0);
        applyStimulus(1, 1'b1, CMD_ACT, 14'h0A1);
        @(negedge clk);
        checkOutput("rrd_first", 32'(gnt), 32'b0010);
        tick();
        applyStimulus(1, 1'b0, CMD_ACT, 14'h0A1);
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            checkOutput("rrd_hold", 32'(gnt), 32'd0);
            if (j == 1) checkDfi("rrd_act1", ENC_ACT, 1, 'h0A1);
            if (j == 2) checkDfi("rrd_nop", ENC_NOP, 1, 'h0A1);
            tick();
        end
        @(negedge clk);
        checkOutput("rrd_second", 32'(gnt), 32'b0001);
        tick();
        applyStimulus(0, 1'b0, CMD_ACT, 14'h0A0);
        @(negedge clk);
        checkOutput("rrd_idle", 32'(gnt), 32'd0);
        checkDfi("rrd_act0", ENC_ACT, 0, 'h0A0);

        // tCCD = 4: blocked RD on bank 1 must not stall PRE on bank 2.
        tick();
        t_ccd = 4'd4;
        applyStimulus(0, 1'b1, CMD_RD, 14'h0C0);
        @(negedge clk);
        checkOutput("ccd_rd0", 32'(gnt), 32'b0001);
        tick();
        applyStimulus(0, 1'b0, CMD_RD, 14'h0C0);
        applyStimulus(1, 1'b1, CMD_RD, 14'h0C1);
        applyStimulus(2, 1'b1, CMD_PRE, 14'h400);
        @(negedge clk);
        checkOutput("ccd_skip", 32'(gnt), 32'b0100);
        checkDfi("ccd_rd0", ENC_RD, 0, 'h0C0);
        tick();
        applyStimulus(2, 1'b0, CMD_PRE, 14'h400);
        @(negedge clk);
        checkOutput("ccd_wait2", 32'(gnt), 32'd0);
        checkDfi("ccd_pre2", ENC_PRE, 2, 'h400);
        tick();
        @(negedge clk);
        checkOutput("ccd_wait3", 32'(gnt), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("ccd_rd1", 32'(gnt), 32'b0010);
        tick();
        applyStimulus(1, 1'b0, CMD_RD, 14'h0C1);
        @(negedge clk);
        checkDfi("ccd_rd1", ENC_RD, 1, 'h0C1);

        // Illegal command code is never granted; counters drain meanwhile.
        tick();
        t_rrd = 4'd0;
        t_ccd = 4'd0;
        applyStimulus(1, 1'b1, 3'd7, 14'h3FF);
        repeat (4) begin
            @(negedge clk);
            checkOutput("illegal", 32'(gnt), 32'd0);
            tick();
        end
        applyStimulus(1, 1'b0, 3'd0, 14'h0);

        // Zero timing with mixed ACT/WR/ACT/RD: one grant every cycle from rr_ptr=2.
        applyStimulus(0, 1'b1, CMD_ACT, 14'h200);
        applyStimulus(1, 1'b1, CMD_WR, 14'h201);
        applyStimulus(2, 1'b1, CMD_ACT, 14'h202);
        applyStimulus(3, 1'b1, CMD_RD, 14'h203);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("zero_gnt", 32'(gnt), 32'(1) << ((2 + k) % 4));
            if (k > 0) checkDfi("zero_dfi", mixed_enc((1 + k) % 4), (1 + k) % 4, 'h200 + (1 + k) % 4);
            tick();
        end

        // Async reset between edges while an ACT is on the bus.
        req_valid = '0;
        t_rrd = 4'd3;
        applyStimulus(0, 1'b1, CMD_ACT, 14'h300);
        @(negedge clk);
        checkOutput("arst_pre_gnt", 32'(gnt), 32'b0001);
        tick();
        #1;
        rst_n = 1'b0;
        for (int b = 0; b < 4; b++) applyStimulus(b, 1'b1, CMD_ACT, 14'(14'h300 + b));
        #1;
        checkDfi("arst_now", ENC_NOP, 0, 0);
        checkOutput("arst_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        checkOutput("arst_hold_gnt", 32'(gnt), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("arst_release_gnt", 32'(gnt), 32'b0001);
        tick();
        req_valid = '0;
        @(negedge clk);
        checkDfi("arst_release", ENC_ACT, 0, 'h300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
